// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock.
// A three-state controller (IDLE -> RUN -> DONE) latches the operands,
// ripples a single borrow flop through WIDTH cycles, then publishes the
// difference together with borrow, signed-overflow and zero flags.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    logic             br_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             zero_q;
    logic             done_q;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] work_d;
    logic             ovf_d;
    logic             zero_d;

    // One full-subtractor slice plus the flags as they would be if this were the last bit.
    // On the last RUN cycle a_bit/b_bit are the operand sign bits and d_bit is the result sign.
    always_comb begin
        a_bit  = a_sr_q[0];
        b_bit  = b_sr_q[0];
        d_bit  = a_bit ^ b_bit ^ br_q;
        br_d   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
        work_d = {d_bit, work_q[WIDTH-1:1]};
        ovf_d  = (a_bit != b_bit) & (d_bit != a_bit);
        zero_d = (work_d == '0);
    end

    // Controller, datapath shift registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        work_q  <= '0;
                        cnt_q   <= '0;
                        br_q    <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    work_q <= work_d;
                    br_q   <= br_d;
                    if (cnt_q == LAST_BIT) begin
                        // Last bit: results become visible together with the done pulse.
                        cnt_q    <= '0;
                        diff_q   <= work_d;
                        borrow_q <= br_d;
                        ovf_q    <= ovf_d;
                        zero_q   <= zero_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, hand-written multi-cycle sequences and
// randomized operations checked against an arithmetic reference model.
// Outputs are sampled 1 time unit after each rising edge; "edge k" counts
// rising edges after the accepting edge (edge 0).
module tb_serial_subtractor;

    localparam int W = 8;
    localparam int P = W + 2;

    typedef struct {
        logic [W-1:0] diff;
        logic         bo;
        logic         ov;
        logic         z;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        res_t         exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;
    logic         zero;

    int   n_cmp  = 0;
    int   n_fail = 0;
    res_t last_exp;
    res_t reset_res;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a_in),
        .b         (b_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain unsigned and signed integer arithmetic.
    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        res_t r;
        int ua = int'(av);
        int ub = int'(bv);
        int sa = av[W-1] ? ua - (1 << W) : ua;
        int sb = bv[W-1] ? ub - (1 << W) : ub;
        int sd = sa - sb;
        r.diff = W'(ua - ub);
        r.bo   = (ua < ub);
        r.ov   = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        r.z    = (r.diff == '0);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic chk_res(input string nm, input res_t e);
        chk({nm, ".diff"}, 32'(diff), 32'(e.diff));
        chk({nm, ".borrow"}, 32'(borrow_out), 32'(e.bo));
        chk({nm, ".overflow"}, 32'(overflow), 32'(e.ov));
        chk({nm, ".zero"}, 32'(zero), 32'(e.z));
    endtask

    // One operation: accept, scramble inputs and poke start while busy,
    // require held outputs until done, then check latency and result.
    task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input res_t e);
        int  lat;
        bit  got_done;
        start = 1'b1;
        a_in  = av;
        b_in  = bv;
        step();
        chk({nm, ".busy_accept"}, 32'(busy), 32'd1);
        lat      = 0;
        got_done = 1'b0;
        while (!got_done && lat < W + 4) begin
            start = (lat == 2);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            step();
            lat++;
            if (done) begin
                got_done = 1'b1;
            end else begin
                chk({nm, ".hold"}, 32'({diff, borrow_out, overflow, zero}),
                    32'({last_exp.diff, last_exp.bo, last_exp.ov, last_exp.z}));
                chk({nm, ".busy_run"}, 32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        chk({nm, ".latency"}, 32'(lat), 32'(W));
        chk({nm, ".busy_done"}, 32'(busy), 32'd1);
        chk_res(nm, e);
        last_exp = e;
        step();
        chk({nm, ".done_pulse"}, 32'(done), 32'd0);
        chk({nm, ".idle"}, 32'(busy), 32'd0);
        $display("op %-8s a=%02h b=%02h -> diff=%02h bo=%0d ov=%0d z=%0d lat=%0d",
                 nm, av, bv, diff, borrow_out, overflow, zero, lat);
    endtask

    initial begin
        vec_t   tbl[7];
        res_t   q[$];
        res_t   e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit     exp_done;
        bit     exp_busy;

        tbl[0] = '{a: 8'h05, b: 8'h03, exp: '{diff: 8'h02, bo: 1'b0, ov: 1'b0, z: 1'b0}};
        tbl[1] = '{a: 8'h03, b: 8'h05, exp: '{diff: 8'hFE, bo: 1'b1, ov: 1'b0, z: 1'b0}};
        tbl[2] = '{a: 8'h80, b: 8'h01, exp: '{diff: 8'h7F, bo: 1'b0, ov: 1'b1, z: 1'b0}};
        tbl[3] = '{a: 8'h7F, b: 8'hFF, exp: '{diff: 8'h80, bo: 1'b1, ov: 1'b1, z: 1'b0}};
        tbl[4] = '{a: 8'h2A, b: 8'h2A, exp: '{diff: 8'h00, bo: 1'b0, ov: 1'b0, z: 1'b1}};
        tbl[5] = '{a: 8'h00, b: 8'h01, exp: '{diff: 8'hFF, bo: 1'b1, ov: 1'b0, z: 1'b0}};
        tbl[6] = '{a: 8'h80, b: 8'h7F, exp: '{diff: 8'h01, bo: 1'b0, ov: 1'b1, z: 1'b0}};

        reset_res = '{diff: '0, bo: 1'b0, ov: 1'b0, z: 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk_res("reset", reset_res);
        last_exp = reset_res;
        rst = 1'b0;

        // Table vectors; the first start coincides with the first edge with rst low.
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp);
        end

        // start at edges W+1 (in DONE) and 3 (in RUN) ignored, start at edge W+2 accepted.
        for (int ed = 0; ed <= W + 11; ed++) begin
            start = (ed == 0) || (ed == 3) || (ed == W + 1) || (ed == W + 2);
            if (ed == 0) begin
                a_in = 8'h10; b_in = 8'h01;
            end else if (ed == W + 2) begin
                a_in = 8'h20; b_in = 8'h30;
            end else if (ed == 3 || ed == W + 1) begin
                a_in = 8'h00; b_in = 8'h40;
            end else begin
                a_in = W'($urandom); b_in = W'($urandom);
            end
            step();
            exp_done = (ed == W) || (ed == W + P);
            exp_busy = (ed <= W) || (ed >= P && ed <= W + P);
            chk($sformatf("ignore.done@%0d", ed), 32'(done), 32'(exp_done));
            chk($sformatf("ignore.busy@%0d", ed), 32'(busy), 32'(exp_busy));
            if (ed == W) chk_res("ignore.first", model(8'h10, 8'h01));
            if (ed == W + P) chk_res("ignore.second", model(8'h20, 8'h30));
        end
        start = 1'b0;
        $display("seq ignore-while-busy done: diff=%02h", diff);

        // start held high: accepts every P edges, operands taken only at accepting edges.
        for (int ed = 0; ed < 3 * P; ed++) begin
            start = 1'b1;
            ra    = W'($urandom);
            rb    = W'($urandom);
            a_in  = ra;
            b_in  = rb;
            if (ed % P == 0) q.push_back(model(ra, rb));
            step();
            chk($sformatf("b2b.done@%0d", ed), 32'(done), 32'((ed % P) == W));
            chk($sformatf("b2b.busy@%0d", ed), 32'(busy), 32'((ed % P) <= W));
            if ((ed % P) == W) begin
                if (q.size() == 0) begin
                    chk("b2b.queue", 32'd0, 32'd1);
                end else begin
                    e = q.pop_front();
                    chk_res($sformatf("b2b@%0d", ed), e);
                    last_exp = e;
                    $display("seq b2b result at edge %0d: diff=%02h", ed, diff);
                end
            end
        end
        start = 1'b0;

        // Reset at edge 4 of an operation aborts it with no done pulse.
        start = 1'b1;
        a_in  = 8'h11;
        b_in  = 8'h22;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk_res("abort", reset_res);
        for (int k = 0; k < W + 4; k++) begin
            step();
            chk($sformatf("abort.nodone@%0d", k), 32'({busy, done}), 32'd0);
        end
        last_exp = reset_res;
        $display("seq abort done: busy=%0d diff=%02h zero=%0d", busy, diff, zero);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 10 == 0) rb = ra;
            run_op($sformatf("rnd%0d", i), ra, rb, model(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
